// File: rtl/sh7604_bsc_lite.sv
// SH7604-style bus state controller: IDLE/T1/TW/T2 access sequencer with
// programmable wait states, 4-beat bursts and locked back-to-back transfers.
module sh7604_bsc_lite #(
    parameter int unsigned WAIT_CYC   = 1,
    parameter int unsigned BURST_WAIT = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic [31:0] DBUS_A,
    input  logic [31:0] DBUS_DO,
    input  logic [3:0]  DBUS_BA,
    input  logic        DBUS_WE,
    input  logic        DBUS_REQ,
    input  logic        DBUS_BURST,
    input  logic        DBUS_LOCK,
    output logic [31:0] DBUS_DI,
    output logic        DBUS_WAIT,
    output logic        BSC_ACK,
    output logic [26:0] MEM_A,
    output logic [31:0] MEM_DO,
    input  logic [31:0] MEM_DI,
    output logic [3:0]  MEM_BE,
    output logic        MEM_RD,
    output logic        MEM_WR,
    input  logic        MEM_RDY
);

    typedef enum logic [1:0] {IDLE, T1, TW, T2} state_t;

    localparam logic [2:0] WAIT_FIRST = 3'(WAIT_CYC);
    localparam logic [2:0] WAIT_BURST = 3'(BURST_WAIT);

    state_t      state_q, state_d;
    logic [26:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [1:0]  beat_q, beat_d;
    logic        burst_q, burst_d;

    logic [2:0]  wait_sel;
    logic [1:0]  beat_nx;
    logic        pending;
    logic        latch;
    logic        latch_first;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^DBUS_A[31:27];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        be_d        = be_q;
        we_d        = we_q;
        wcnt_d      = wcnt_q;
        beat_d      = beat_q;
        burst_d     = burst_q;
        latch       = 1'b0;
        latch_first = 1'b0;
        wait_sel    = (beat_q == 2'd0) ? WAIT_FIRST : WAIT_BURST;
        // beat_nx wraps to 0 after the fourth beat, which ends the burst
        beat_nx     = burst_q ? beat_q + 2'd1 : 2'd0;
        pending     = burst_q && (beat_nx != 2'd0);

        unique case (state_q)
            IDLE: begin
                if (DBUS_REQ) begin
                    latch       = 1'b1;
                    latch_first = 1'b1;
                    state_d     = T1;
                end
            end
            T1: begin
                if (wait_sel != '0) begin
                    state_d = TW;
                    wcnt_d  = wait_sel - 3'd1;
                end else begin
                    wcnt_d  = '0;
                    state_d = MEM_RDY ? T2 : TW;
                end
            end
            TW: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else if (MEM_RDY) begin
                    state_d = T2;
                end
            end
            T2: begin
                state_d = IDLE;
                beat_d  = '0;
                burst_d = 1'b0;
                if (DBUS_REQ && (DBUS_LOCK || pending)) begin
                    latch       = 1'b1;
                    latch_first = !pending;
                    state_d     = T1;
                    beat_d      = beat_nx;
                    burst_d     = pending;
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            addr_d = DBUS_A[26:0];
            wdat_d = DBUS_DO;
            be_d   = DBUS_BA;
            we_d   = DBUS_WE;
        end
        if (latch_first) begin
            burst_d = DBUS_BURST;
        end
        if ((state_d == T2) && (state_q != T2) && !we_q) begin
            rdat_d = MEM_DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wcnt_q  <= '0;
            beat_q  <= '0;
            burst_q <= 1'b0;
        end else if (CE_R) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            be_q    <= be_d;
            we_q    <= we_d;
            wcnt_q  <= wcnt_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end

    assign DBUS_WAIT = DBUS_REQ && (state_q != T2);
    assign BSC_ACK   = (state_q == T2);
    assign MEM_RD    = !we_q && ((state_q == T1) || (state_q == TW));
    assign MEM_WR    = we_q && ((state_q == T1) || (state_q == TW));
    assign MEM_A     = addr_q;
    assign MEM_DO    = wdat_q;
    assign MEM_BE    = be_q;
    assign DBUS_DI   = rdat_q;

endmodule
